// File: rtl/mlp_pkg.sv
// Shared types and sizing for the MLP datapath and the output-layer argmax.
package mlp_pkg;

  localparam int NUM_OUT = 10;
  localparam int IDX_W   = 4;

  typedef logic signed [15:0] score_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/max_cmp2.sv
// Combinational signed compare/select of two (value, index) candidates.
// B replaces A only when strictly greater, so ties keep the A (earlier) entry.
module max_cmp2 #(
  parameter int DW    = 16,
  parameter int IDX_W = 4
) (
  input  logic signed [DW-1:0]    i_a_val,
  input  logic        [IDX_W-1:0] i_a_idx,
  input  logic signed [DW-1:0]    i_b_val,
  input  logic        [IDX_W-1:0] i_b_idx,
  output logic                    o_greater,
  output logic signed [DW-1:0]    o_val,
  output logic        [IDX_W-1:0] o_idx
);

  // Select the larger candidate; tie keeps A
  always_comb begin
    o_greater = (i_b_val > i_a_val);
    o_val     = o_greater ? i_b_val : i_a_val;
    o_idx     = o_greater ? i_b_idx : i_a_idx;
  end

endmodule

// File: rtl/output_argmax.sv
// Running argmax over one image's output-layer scores, reported to the host
// through a valid/ack handshake.
module output_argmax #(
  parameter int NUM_CLASSES = mlp_pkg::NUM_OUT,
  parameter int DW          = 16,
  parameter int IDX_W       = mlp_pkg::IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 score_valid,
  output logic                 score_ready,
  input  logic signed [DW-1:0] score_data,
  input  logic                 score_last,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [IDX_W-1:0]     result_class,
  output logic [DW-1:0]        result_score,
  output logic                 err_len,
  output logic                 busy
);

  import mlp_pkg::*;

  localparam logic [IDX_W:0] LP_NUM = (IDX_W+1)'(NUM_CLASSES);
  localparam logic [IDX_W:0] LP_ONE = (IDX_W+1)'(1);

  argmax_state_t         r_state;
  logic signed [DW-1:0]  r_best_val;
  logic [IDX_W-1:0]      r_best_idx;
  logic [IDX_W:0]        r_cnt;
  logic                  r_err_len;

  logic                  w_xfer;
  logic                  w_full;
  logic [IDX_W:0]        w_cnt_inc;
  logic                  w_greater;
  logic signed [DW-1:0]  w_sel_val;
  logic [IDX_W-1:0]      w_sel_idx;

  assign w_xfer    = score_valid && score_ready;
  assign w_full    = (r_cnt == LP_NUM);
  assign w_cnt_inc = r_cnt + LP_ONE;

  max_cmp2 #(
    .DW    (DW),
    .IDX_W (IDX_W)
  ) u_cmp (
    .i_a_val   (r_best_val),
    .i_a_idx   (r_best_idx),
    .i_b_val   (score_data),
    .i_b_idx   (r_cnt[IDX_W-1:0]),
    .o_greater (w_greater),
    .o_val     (w_sel_val),
    .o_idx     (w_sel_idx)
  );

  // Handshake/status outputs decoded from the state register
  always_comb begin
    score_ready  = (r_state != REPORT);
    result_valid = (r_state == REPORT);
    busy         = (r_state == COLLECT);
    result_class = r_best_idx;
    result_score = r_best_val;
    err_len      = r_err_len;
  end

  // FSM, running maximum, score counter and length-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
      r_err_len  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_best_val <= score_data;
            r_best_idx <= '0;
            r_cnt      <= LP_ONE;
            // A one-score image is always short since NUM_CLASSES >= 2
            r_err_len  <= score_last;
            r_state    <= score_last ? REPORT : COLLECT;
          end
        end
        COLLECT: begin
          if (w_xfer) begin
            // Once the counter is saturated, extra scores are swallowed uncompared
            if (!w_full) begin
              r_cnt <= w_cnt_inc;
              if (w_greater) begin
                r_best_val <= w_sel_val;
                r_best_idx <= w_sel_idx;
              end
            end
            if (score_last) begin
              r_err_len <= r_err_len || w_full || (w_cnt_inc != LP_NUM);
              r_state   <= REPORT;
            end else if (w_full) begin
              r_err_len <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (result_ack) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: hand-computed argmax results per image.
module tb_output_argmax;

  logic              clk;
  logic              rst;
  logic              score_valid;
  logic              score_ready;
  logic signed [15:0] score_data;
  logic              score_last;
  logic              result_valid;
  logic              result_ack;
  logic [3:0]        result_class;
  logic [15:0]       result_score;
  logic              err_len;
  logic              busy;

  int n_checks;
  int n_fail;

  output_argmax #(
    .NUM_CLASSES (10),
    .DW          (16),
    .IDX_W       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .score_valid  (score_valid),
    .score_ready  (score_ready),
    .score_data   (score_data),
    .score_last   (score_last),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .result_class (result_class),
    .result_score (result_score),
    .err_len      (err_len),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present each score in turn; caller is aligned at posedge+1.
  task automatic send_image(input int s[$], input bit with_last);
    int wait_n;
    for (int i = 0; i < s.size(); i++) begin
      score_valid = 1'b1;
      score_data  = 16'(s[i]);
      score_last  = with_last && (i == s.size() - 1);
      wait_n = 0;
      @(negedge clk);
      while (!score_ready && wait_n < 50) begin
        wait_n++;
        @(negedge clk);
      end
      check("ready_wait", int'(score_ready), 1);
      @(posedge clk);
      #1;
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  // Sample the result one cycle after the last transfer; ack must already be high.
  task automatic check_result(input string tag, input int cls, input int val, input int err);
    @(negedge clk);
    check({tag, "_valid"}, int'(result_valid), 1);
    check({tag, "_class"}, int'(result_class), cls);
    check({tag, "_score"}, int'($signed(result_score)), val);
    check({tag, "_err"},   int'(err_len), err);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, int'(result_valid), 0);
    check({tag, "_class"}, int'(result_class), 0);
    check({tag, "_score"}, int'(result_score), 0);
    check({tag, "_err"},   int'(err_len), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_ready"}, int'(score_ready), 1);
  endtask

  initial begin
    int img_a[$];
    int img_b[$];
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    score_valid = 1'b0;
    score_data  = '0;
    score_last  = 1'b0;
    result_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;

    // 1: tie on 100 keeps index 2; one-cycle latency, then ack returns to idle
    result_ack = 1'b1;
    send_image('{5, -3, 100, 7, 100, 0, 0, 0, 0, 2}, 1'b1);
    check_result("t1", 2, 100, 0);
    @(negedge clk);
    check("t1_valid_after_ack", int'(result_valid), 0);
    @(posedge clk);
    #1;

    // 2: all-negative scores exercise the signed compare
    send_image('{-50, -2, -9, -2, -100, -7, -8, -3, -4, -5}, 1'b1);
    check_result("t2", 1, -2, 0);

    // 3: back-to-back images, ack delayed 3 cycles, valid held high throughout
    result_ack = 1'b0;
    img_a = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -1};
    img_b = '{300, 1, 2, 3, 4, 5, 6, 7, 8, 299};
    send_image(img_a, 1'b1);
    fork
      send_image(img_b, 1'b1);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("t3_hold_valid", int'(result_valid), 1);
          check("t3_hold_class", int'(result_class), 8);
          check("t3_hold_score", int'($signed(result_score)), 90);
          check("t3_hold_ready", int'(score_ready), 0);
        end
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
      end
    join
    result_ack = 1'b1;
    check_result("t3b", 0, 300, 0);

    // 4: short image flags err_len; a correct image clears it
    send_image('{1, 2, 3, 4, 5, 6, 50}, 1'b1);
    check_result("t4_short", 6, 50, 1);
    send_image('{3, 1, 4, 1, 5, 9, 2, 6, 5, 3}, 1'b1);
    check_result("t4_ok", 5, 9, 0);

    // 5: scores past NUM_CLASSES (incl. 0x7FFF at index 11) are not compared
    send_image('{1, 2, 3, 4, 5, 6, 7, 8, 40, 9, 10, 32767, 11}, 1'b1);
    check_result("t5", 8, 40, 1);

    // 6: reset mid-image discards the partial maximum
    send_image('{7, 1000, -5, 3}, 1'b0);
    check("t6_busy_pre", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_rst");
    @(posedge clk);
    #1;
    send_image('{0, 1, 2, 3, 4, 5, 6, 7, 8, 20}, 1'b1);
    check_result("t6", 9, 20, 0);

    result_ack = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Consumes the 10 output-layer neuron scores for one image as a serial valid/ready stream and tracks the running maximum.
- Reports the predicted digit (0-9) and its score to the host with a valid/ack handshake.
- Sits between the output-layer neuron array and the top-level result interface; it is the reading end of the neuron output bus.
- Scores are signed 16-bit two's-complement fixed point. The output layer has no ReLU, so negative scores are legal.

Parameters:
- NUM_CLASSES, 10, number of scores per image (2..16).
- DW, 16, score width in bits.
- IDX_W, 4, class index width; must satisfy 2**IDX_W >= NUM_CLASSES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- score_valid  in  1  score_data/score_last are valid this cycle.
- score_ready  out  1  block accepts a score this cycle.
- score_data  in  DW  signed score of the current class.
- score_last  in  1  marks the final score of an image.
- result_valid  out  1  result_class/result_score are valid.
- result_ack  in  1  host consumes the result.
- result_class  out  IDX_W  index of the maximum score.
- result_score  out  DW  maximum score value.
- err_len  out  1  sticky flag; last image had a score count different from NUM_CLASSES.
- busy  out  1  high while in COLLECT.

Behaviour:
- Transfer rule: a score transfers when score_valid && score_ready are high on a rising clk edge.
- State IDLE:
  - score_ready=1.
  - A transfer loads best_val=score_data, best_idx=0, cnt=1.
  - If score_last is also set, go to REPORT; otherwise go to COLLECT.
- State COLLECT:
  - score_ready=1, busy=1.
  - Each transfer compares score_data with best_val as signed values.
  - On strictly greater, load best_val=score_data and best_idx=cnt. On a tie, the earlier index wins.
  - cnt is incremented on every transfer.
  - A transfer with score_last set goes to REPORT.
- Count overrun:
  - If cnt reaches NUM_CLASSES and a further score arrives without score_last, that score is consumed but not compared.
  - err_len is set, and the block continues until score_last.
- State REPORT:
  - score_ready=0, result_valid=1.
  - result_class and result_score are held stable until result_ack.
  - result_ack=1 returns to IDLE.
  - result_ack received in the same cycle result_valid first rises is legal and completes the handshake.
- err_len:
  - Computed on the score_last transfer: set if the final count != NUM_CLASSES.
  - Cleared on the first transfer of the next image.
- Latency: result_valid rises 1 cycle after the score_last transfer.
- Throughput: 1 score per cycle. One bubble per image for REPORT plus the ack cycle.
- result_ack outside REPORT is ignored.
- Reset values (any state, including mid-image):
  - State goes to IDLE; the partial image is discarded.
  - score_ready=1 (IDLE value).
  - result_valid=0, result_class=0, result_score=0, err_len=0, busy=0, cnt=0.
- Comparison is full DW-bit signed. There is no saturation and no arithmetic beyond compare and increment.
- cnt is IDX_W+1 bits wide and saturates at NUM_CLASSES so it cannot wrap.

Decomposition:
- Shared package mlp_pkg:
  - typedef score_t (logic signed [15:0]).
  - localparams NUM_OUT=10, IDX_W=4.
  - enum argmax_state_t {IDLE, COLLECT, REPORT}.
  - The neuron layers also use score_t.
- Sub-module max_cmp2: a combinational signed compare/select returning (greater, val, idx).
  - It is reusable later for a tree argmax.
  - The FSM, counter and registers stay in output_argmax.

Test Plan:
1. Scores 5,-3,100,7,100,0,0,0,0,2 (last on the 10th), result_ack held high:
   - result_class=2, result_score=100 (tie keeps index 2).
   - result_valid high exactly 1 cycle after the last transfer; err_len=0.
2. All scores negative: -50,-2,-9,-2,-100,-7,-8,-3,-4,-5:
   - result_class=1, result_score=-2; confirms signed compare (0xFFFE > 0xFFCE).
3. Back-to-back images with score_valid always high, result_ack delayed 3 cycles:
   - score_ready=0 during REPORT and no score is lost.
   - The second image's result is correct; result outputs stay stable while unacked.
4. Short image of 7 scores with last on the 7th, max at index 6:
   - result_class=6 and err_len=1.
   - A following correct 10-score image clears err_len.
5. 13 scores, largest (0x7FFF) at index 11, last on the 13th:
   - Scores beyond NUM_CLASSES are ignored, so result_class<=9; err_len=1.
6. Assert rst after 4 scores mid-image, then send a fresh 10-score image with max at index 9:
   - All outputs are 0 the cycle after reset.
   - result_class=9, with no contamination from the aborted image.
